adder_rr_arbiter: RTL and testbench
===================================

Name: adder_rr_arbiter

Overview:
- Shares one 20-bit ripple-carry adder (adder_20b) between NREQ requesters in the upscaler datapath.
- Interpolation and accumulation units can therefore time-multiplex a single adder instead of each instantiating their own.
- Grants one request per cycle using round-robin arbitration and registers the sum into a single-entry output stage.
- The output stage carries a valid/ready handshake, a requester tag and a derived carry-out.

Parameters:
NREQ, 4, number of requesters (2..8)
TAG_W, 2, width of res_tag; must equal ceil(log2(NREQ))
CNT_W, 16, width of the op_count statistics counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  per-requester operand-valid
req_a  input  NREQ*20  operand A, requester i at bits [20*i+19:20*i]
req_b  input  NREQ*20  operand B, same packing
req_ready  output  NREQ  per-requester grant/accept, one-hot or zero
res_valid  output  1  result register holds a valid sum
res_ready  input  1  downstream accepts the result
res_sum  output  20  registered a+b modulo 2^20
res_carry  output  1  carry-out of the registered addition
res_tag  output  TAG_W  index of the requester that produced res_sum
op_count  output  CNT_W  number of accepted transfers, wraps

Behaviour:
- Reset (rst_n low, asynchronous): res_valid=0, res_sum=0, res_carry=0, res_tag=0, op_count=0, rr_ptr=NREQ-1.
  - With rr_ptr=NREQ-1, requester 0 has highest priority after reset.
- Stage enable: accept = !res_valid || res_ready. This is combinational, so a pipeline-style same-cycle refill is allowed.
- Arbitration (combinational): scan indices rr_ptr+1, rr_ptr+2, ... modulo NREQ. g = the first index i with req_valid[i]=1.
- req_ready[g] = accept && any(req_valid). All other req_ready bits = 0.
  - req_ready depends combinationally on res_ready and req_valid. It is never asserted for a requester whose valid is low.
- Transfer occurs when req_valid[g] && req_ready[g]. On the next clock edge:
  - res_sum <= sum from the internal adder_20b instance, inputs muxed from requester g.
  - res_carry <= (sum < a_g), unsigned compare; adder_20b has no carry port.
  - res_tag <= g; res_valid <= 1; rr_ptr <= g; op_count <= op_count+1, wrapping at 2^CNT_W.
- Latency is 1 cycle from transfer to res_valid. Throughput is 1 result per cycle while res_ready=1.
- Result drained with no new transfer (res_valid && res_ready, no request): res_valid <= 0 next edge. res_sum, res_carry and res_tag hold their last values.
- Stall (res_valid && !res_ready): every req_ready=0 and all res_* outputs hold stable. rr_ptr holds.
- No requests: rr_ptr and op_count hold.
- Fairness: a requester holding req_valid high is granted within NREQ accepted transfers.
- Requester rule: a_i and b_i stay stable while req_valid[i]=1 and req_ready[i]=0. The arbiter does not check this.
- Arithmetic is unsigned modulo 2^20. Overflow is reported only through res_carry, never saturated.
- Reset asserted mid-stream: an in-flight result is discarded (res_valid=0 immediately) and the priority pointer returns to NREQ-1.

Test Plan:
- Reset release, all req_valid=0, res_ready=1 -> every req_ready=0, res_valid=0, op_count=0 for 10 cycles.
- req_valid=4'b0001, a0=100, b0=23 -> req_ready=0001 in the same cycle; next cycle res_valid=1, res_sum=123, res_carry=0, res_tag=0, op_count=1.
- All four valid and held, res_ready=1, a_i=i, b_i=1000 -> grant order 0,1,2,3,0,…; res_sum sequence 1000,1001,1002,1003,1000; one result per cycle.
- a=20'hFFFFF, b=20'h00002 -> res_sum=20'h00001, res_carry=1. Then a=20'h7FFFF, b=1 -> res_sum=20'h80000, res_carry=0.
- All valid, res_ready held low 5 cycles after the first result -> req_ready=0, res_sum/res_tag stable for 5 cycles. On release, the next grant goes to rr_ptr+1 and no result is lost or duplicated.
- Pull rst_n low between edges while res_valid=1 -> res_valid drops immediately, without waiting for a clock edge. After release, requester 0 wins when all are valid; op_count restarts at 0. Then run 65536 transfers -> op_count wraps to 0.

Source files
------------

// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter that time-shares one 20-bit ripple-carry adder between
// NREQ requesters and registers the winning sum into a valid/ready output stage.

module adder_20b (
    input  logic [19:0] a,
    input  logic [19:0] b,
    output logic [19:0] sum
);

    logic [19:0] carry;

    assign carry[0] = 1'b0;

    // The carry out of bit 19 is dropped on purpose; callers recover it by comparison.
    for (genvar i = 0; i < 20; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < 19) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
    end

endmodule

module adder_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*20-1:0]   req_a,
    input  logic [NREQ*20-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [19:0]          res_sum,
    output logic                 res_carry,
    output logic [TAG_W-1:0]     res_tag,
    output logic [CNT_W-1:0]     op_count
);

    logic [TAG_W-1:0] rr_ptr;
    logic [TAG_W-1:0] grant_idx;
    logic             grant_found;
    logic             accept;
    logic             transfer;
    logic [19:0]      a_g;
    logic [19:0]      b_g;
    logic [19:0]      sum_g;
    logic             carry_g;

    assign accept = !res_valid || res_ready;

    // Scan starting just after the last winner so every requester gets a turn.
    always_comb begin
        logic [TAG_W-1:0] cand;
        grant_idx   = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = TAG_W'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (accept && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign transfer = accept && grant_found;

    assign a_g = req_a[20*grant_idx +: 20];
    assign b_g = req_b[20*grant_idx +: 20];

    adder_20b u_adder (
        .a   (a_g),
        .b   (b_g),
        .sum (sum_g)
    );

    // A wrapped sum is smaller than either operand.
    assign carry_g = (sum_g < a_g);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_tag   <= '0;
            op_count  <= '0;
            rr_ptr    <= TAG_W'(NREQ - 1);
        end else if (transfer) begin
            res_valid <= 1'b1;
            res_sum   <= sum_g;
            res_carry <= carry_g;
            res_tag   <= grant_idx;
            op_count  <= op_count + 1'b1;
            rr_ptr    <= grant_idx;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed self-checking bench for adder_rr_arbiter with hand-computed results.

module tb_adder_rr_arbiter;

    localparam int NREQ  = 4;
    localparam int TAG_W = 2;
    localparam int CNT_W = 16;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*20-1:0]  req_a;
    logic [NREQ*20-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic                res_valid;
    logic                res_ready;
    logic [19:0]         res_sum;
    logic                res_carry;
    logic [TAG_W-1:0]    res_tag;
    logic [CNT_W-1:0]    op_count;

    int errors = 0;
    int checks = 0;

    adder_rr_arbiter #(.NREQ(NREQ), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_tag   (res_tag),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [19:0] a, input logic [19:0] b);
        req_a[20*idx +: 20] = a;
        req_b[20*idx +: 20] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic loadRamp();
        for (int i = 0; i < NREQ; i++) applyStimulus(i, 20'(i), 20'd1000);
    endtask

    int exp_tag [5] = '{1, 2, 3, 0, 1};
    int exp_nxt [5] = '{2, 3, 0, 1, 2};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        #12;
        rst_n = 1'b1;

        // Idle after reset
        checkOutput("reset_sum", 32'(res_sum), 32'd0);
        checkOutput("reset_tag", 32'(res_tag), 32'd0);
        checkOutput("reset_carry", 32'(res_carry), 32'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            checkOutput("idle_ready", 32'(req_ready), 32'd0);
            checkOutput("idle_valid", 32'(res_valid), 32'd0);
            checkOutput("idle_count", 32'(op_count), 32'd0);
        end

        // Single transfer from requester 0
        applyStimulus(0, 20'd100, 20'd23);
        req_valid = 4'b0001;
        #1;
        checkOutput("single_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        checkOutput("single_valid", 32'(res_valid), 32'd1);
        checkOutput("single_sum", 32'(res_sum), 32'd123);
        checkOutput("single_carry", 32'(res_carry), 32'd0);
        checkOutput("single_tag", 32'(res_tag), 32'd0);
        checkOutput("single_count", 32'(op_count), 32'd1);
        step();
        checkOutput("drain_valid", 32'(res_valid), 32'd0);
        checkOutput("drain_sum_hold", 32'(res_sum), 32'd123);
        checkOutput("drain_tag_hold", 32'(res_tag), 32'd0);

        // All requesters valid; pointer sits at 0 so rotation starts at 1
        loadRamp();
        req_valid = 4'b1111;
        #1;
        checkOutput("rr_first_ready", 32'(req_ready), 32'b0010);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput("rr_valid", 32'(res_valid), 32'd1);
            checkOutput("rr_tag", 32'(res_tag), 32'(exp_tag[k]));
            checkOutput("rr_sum", 32'(res_sum), 32'(1000 + exp_tag[k]));
            checkOutput("rr_count", 32'(op_count), 32'(2 + k));
            checkOutput("rr_next_ready", 32'(req_ready), 32'(1 << exp_nxt[k]));
        end
        req_valid = '0;
        step();
        checkOutput("rr_drain", 32'(res_valid), 32'd0);

        // Carry boundaries, back to back; pointer is 1
        applyStimulus(2, 20'hFFFFF, 20'h00002);
        req_valid = 4'b0100;
        step();
        checkOutput("ovf_sum", 32'(res_sum), 32'h00001);
        checkOutput("ovf_carry", 32'(res_carry), 32'd1);
        checkOutput("ovf_tag", 32'(res_tag), 32'd2);
        applyStimulus(3, 20'h7FFFF, 20'h00001);
        req_valid = 4'b1000;
        step();
        checkOutput("half_sum", 32'(res_sum), 32'h80000);
        checkOutput("half_carry", 32'(res_carry), 32'd0);
        checkOutput("half_tag", 32'(res_tag), 32'd3);
        applyStimulus(1, 20'hFFFFF, 20'h00001);
        req_valid = 4'b0010;
        step();
        checkOutput("wrap0_sum", 32'(res_sum), 32'h00000);
        checkOutput("wrap0_carry", 32'(res_carry), 32'd1);
        checkOutput("wrap0_count", 32'(op_count), 32'd9);
        req_valid = '0;
        step();
        checkOutput("ovf_drain", 32'(res_valid), 32'd0);

        // Stall: pointer is 1, so requester 2 wins first, then 3 after release
        loadRamp();
        req_valid = 4'b1111;
        step();
        checkOutput("stall_first_tag", 32'(res_tag), 32'd2);
        res_ready = 1'b0;
        #1;
        checkOutput("stall_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput("stall_valid", 32'(res_valid), 32'd1);
            checkOutput("stall_tag", 32'(res_tag), 32'd2);
            checkOutput("stall_sum", 32'(res_sum), 32'd1002);
            checkOutput("stall_ready_hold", 32'(req_ready), 32'd0);
            checkOutput("stall_count", 32'(op_count), 32'd10);
        end
        res_ready = 1'b1;
        #1;
        checkOutput("release_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        checkOutput("release_tag", 32'(res_tag), 32'd3);
        checkOutput("release_sum", 32'(res_sum), 32'd1003);
        checkOutput("release_count", 32'(op_count), 32'd11);
        step();
        checkOutput("release_drain", 32'(res_valid), 32'd0);

        // Asynchronous reset while a result is held
        applyStimulus(3, 20'd5, 20'd6);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        res_ready = 1'b0;
        checkOutput("pre_rst_valid", 32'(res_valid), 32'd1);
        checkOutput("pre_rst_sum", 32'(res_sum), 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(res_valid), 32'd0);
        checkOutput("async_rst_count", 32'(op_count), 32'd0);
        checkOutput("async_rst_sum", 32'(res_sum), 32'd0);
        #1;
        rst_n = 1'b1;
        res_ready = 1'b1;
        loadRamp();
        req_valid = 4'b1111;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'b0001);

        // 65536 transfers wrap the counter back to zero
        step();
        checkOutput("post_rst_tag", 32'(res_tag), 32'd0);
        checkOutput("post_rst_count", 32'(op_count), 32'd1);
        for (int c = 1; c < 65536; c++) step();
        req_valid = '0;
        checkOutput("wrap_count", 32'(op_count), 32'd0);
        checkOutput("wrap_tag", 32'(res_tag), 32'd3);
        checkOutput("wrap_sum", 32'(res_sum), 32'd1003);
        step();
        checkOutput("wrap_hold_count", 32'(op_count), 32'd0);
        checkOutput("wrap_drain", 32'(res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
